// File: rtl/mirfak_wb_arbiter_if.sv
// Wishbone B4 classic point-to-point bundle: one master side, one slave side.
interface mirfak_wb_arbiter_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic [AW-1:0] addr;
   logic [DW-1:0] wdat;
   logic [DW-1:0] rdat;
   logic [SW-1:0] sel;
   logic          cyc;
   logic          stb;
   logic          we;
   logic          ack;
   logic          err;

   modport master (output addr, wdat, sel, cyc, stb, we, input rdat, ack, err);
   modport slave  (input addr, wdat, sel, cyc, stb, we, output rdat, ack, err);
endinterface

// File: rtl/mirfak_wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter (instruction / data ports onto one bus)
// with bus hold until completion and a watchdog that turns a hung slave into a bus error.
module mirfak_wb_arbiter #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   mirfak_wb_arbiter_if.slave   iwbm,
   mirfak_wb_arbiter_if.slave   dwbm,
   mirfak_wb_arbiter_if.master  wbm
);
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned TW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam int unsigned TLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam bit          WD_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {S_IDLE, S_OWN_I, S_OWN_D} state_e;
   typedef enum logic       {OWNER_I, OWNER_D} owner_e;

   state_e        state_q, state_d;
   owner_e        last_q, last_d;
   logic [TW-1:0] timer_q, timer_d;

   logic          own_i, own_d, owning;
   logic          req_i, req_d;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdat;
   logic [SW-1:0] m_sel;
   logic          m_cyc, m_stb, m_we;
   logic          timeout_c, resp_en, resp_ack, resp_err;

   // Select the current owner's request fields
   always_comb begin
      own_i  = (state_q == S_OWN_I);
      own_d  = (state_q == S_OWN_D);
      owning = own_i | own_d;
      req_i  = iwbm.cyc & iwbm.stb;
      req_d  = dwbm.cyc & dwbm.stb;
      m_addr = own_d ? dwbm.addr : iwbm.addr;
      m_wdat = own_d ? dwbm.wdat : iwbm.wdat;
      m_sel  = own_d ? dwbm.sel  : iwbm.sel;
      m_cyc  = own_d ? dwbm.cyc  : iwbm.cyc;
      m_stb  = own_d ? dwbm.stb  : iwbm.stb;
      m_we   = own_d ? dwbm.we   : iwbm.we;
   end

   // Bus drive and response routing; an error (slave or watchdog) always masks ack
   always_comb begin
      wbm.addr = '0;
      wbm.wdat = '0;
      wbm.sel  = '0;
      wbm.cyc  = 1'b0;
      wbm.stb  = 1'b0;
      wbm.we   = 1'b0;
      if (owning) begin
         wbm.addr = m_addr;
         wbm.wdat = m_wdat;
         wbm.sel  = m_sel;
         wbm.cyc  = m_cyc;
         wbm.stb  = m_cyc & m_stb;
         wbm.we   = m_cyc & m_we;
      end

      timeout_c = WD_EN & owning & (timer_q == TW'(TLAST));
      resp_en   = owning & m_cyc & ~rst_i;
      resp_err  = resp_en & (wbm.err | timeout_c);
      resp_ack  = resp_en & wbm.ack & ~wbm.err & ~timeout_c;

      iwbm.ack  = own_i & resp_ack;
      iwbm.err  = own_i & resp_err;
      dwbm.ack  = own_d & resp_ack;
      dwbm.err  = own_d & resp_err;
      iwbm.rdat = wbm.rdat;
      dwbm.rdat = wbm.rdat;
   end

   // Arbitration, ownership release and watchdog timer
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      timer_d = timer_q;
      case (state_q)
         S_IDLE: begin
            if (req_i && req_d) begin
               state_d = (last_q == OWNER_I) ? S_OWN_D : S_OWN_I;
               last_d  = (last_q == OWNER_I) ? OWNER_D : OWNER_I;
               timer_d = '0;
            end else if (req_d) begin
               state_d = S_OWN_D;
               last_d  = OWNER_D;
               timer_d = '0;
            end else if (req_i) begin
               state_d = S_OWN_I;
               last_d  = OWNER_I;
               timer_d = '0;
            end
         end
         S_OWN_I, S_OWN_D: begin
            if (wbm.ack || wbm.err || !m_cyc || timeout_c) begin
               state_d = S_IDLE;
            end else if (WD_EN && (timer_q != TW'(TIMEOUT))) begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         last_q  <= OWNER_I;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         timer_q <= timer_d;
      end
   end
endmodule
